ysyx_22041071_hazard_ctrl: RTL and testbench
============================================

# ysyx_22041071_hazard_ctrl

Pipeline hazard controller for the five-stage RV64 core. It sits beside the ID stage and compares the decoded source registers against the destinations in EX and MEM. It drives operand-forward selects, load-use stalls, multi-cycle MUL/DIV hold, and post-branch flush sequencing for the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
Parameters:
- MDU_MAX, 64, max cycles a MUL/DIV may hold EX before forced release
- FLUSH_LAT, 1, extra cycles ID is killed after a redirect (fetch in flight), 1..7
- CNT_W, 32, width of stall performance counter

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs, id_rt  in  5  decoded source registers
- id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt
- ex_valid, ex_reg_w_en, ex_is_load  in  1  EX-stage qualifiers (ex_is_load = WB_sel of EX)
- ex_rd  in  5  EX destination
- ex_is_mdu  in  1  EX ALU_ctrl is a MUL/DIV/REM op (19..30)
- ex_redirect  in  1  EX resolved taken branch / jal / jalr
- mem_valid, mem_reg_w_en  in  1  MEM-stage qualifiers
- mem_rd  in  5  MEM destination
- mdu_done  in  1  MUL/DIV result valid this cycle
- stall_if, stall_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- hold_ex  out  1  freeze ID/EX and EX result
- bubble_mem  out  1  load NOP into EX/MEM
- flush_id  out  1  kill IF/ID contents
- fwd1, fwd2  out  2  0 = regfile, 1 = EX result, 2 = MEM/WB data
- mdu_timeout  out  1  sticky; MDU_MAX was exceeded
- stall_cnt  out  CNT_W  cycles with stall_id = 1, saturating

## Operation
- FSM states: RUN, MDU_WAIT, FLUSH. Outputs are combinational from state and inputs. State and counters are registered.
- Match rules:
  - hitEX(r) = ex_valid & ex_reg_w_en & ex_rd == r & r != 0
  - hitMEM(r) = mem_valid & mem_reg_w_en & mem_rd == r & r != 0
  - A source is checked only if its id_use_* bit is 1 and id_valid is 1.
- Forwarding (every state): fwdN = 1 if hitEX & !ex_is_load; else 2 if hitMEM; else 0. EX has priority over MEM.
- RUN, evaluated in priority order:
  1. ex_redirect & ex_valid: flush_id = 1; next = FLUSH with fcnt = FLUSH_LAT. If FLUSH_LAT = 0, stay in RUN.
  2. ex_valid & ex_is_mdu & !mdu_done: stall_if = stall_id = hold_ex = bubble_mem = 1; next = MDU_WAIT with mcnt = 1.
  3. Load-use (hitEX on a checked source & ex_is_load): stall_if = stall_id = bubble_ex = 1 for this one cycle only. Next cycle the load is in MEM and fwd = 2.
  4. Otherwise all control outputs are 0.
- MDU_WAIT:
  - stall_if, stall_id, hold_ex, bubble_mem = 1 while !mdu_done. mcnt increments each cycle.
  - mdu_done: all four outputs drop in the same cycle; next = RUN.
  - mcnt == MDU_MAX without mdu_done: set mdu_timeout, release as if done, next = RUN.
- FLUSH: flush_id = 1 and all stall outputs are 0. fcnt decrements; at fcnt == 1 the next state is RUN.
- stall_cnt increments on every cycle with stall_id = 1 and saturates at all-ones.

## Timing
- Reset low (asynchronous):
  - state = RUN; mcnt = fcnt = 0; mdu_timeout = 0; stall_cnt = 0.
  - Combinational outputs still follow the inputs, with state = RUN.
- Reset asserted mid-MDU_WAIT or mid-FLUSH returns to RUN immediately. No stall persists past the deassertion edge.
- Load-use costs exactly 1 stall cycle.
- An MUL/DIV with latency L costs L-1 stall cycles. mdu_done in the first EX cycle costs 0.
- A redirect kills ID for 1 + FLUSH_LAT cycles.
- A redirect coincident with a load-use or MDU condition: redirect wins; no stall or bubble that cycle.
- In FLUSH state, load-use and MDU conditions are ignored because ID is killed.
- A source of x0 never forwards and never stalls.
- mdu_timeout clears only on reset.

## Test plan
- EX add writes x5 while ID reads x5 (rs) -> fwd1 = 1, no stall. Same with MEM only -> fwd1 = 2.
- EX ld writes x7 while ID add reads x7 (rt) -> stall_if = stall_id = bubble_ex = 1 for 1 cycle. Next cycle fwd2 = 2 and stalls are 0. stall_cnt = 1.
- EX div with mdu_done arriving 5 cycles after entry -> hold_ex = bubble_mem = stall_id = 1 for cycles 0-4, released in cycle 5 when mdu_done is 1. stall_cnt = 5.
- mdu_done held 0 with MDU_MAX = 64 -> release after 64 stall cycles; mdu_timeout = 1 and stays 1.
- ex_redirect together with a load-use match, FLUSH_LAT = 1 -> flush_id = 1 for 2 cycles, bubble_ex = 0, stall_cnt unchanged.
- reset driven low during cycle 3 of MDU_WAIT -> all stall outputs 0 immediately and state = RUN. ID reading x0 while EX writes x0 -> fwd = 0, no stall.

Source files
------------

// File: rtl/ysyx_22041071_hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: operand forwarding selects,
// load-use stalls, MUL/DIV hold with a timeout, and post-redirect flush sequencing.
module ysyx_22041071_hazard_ctrl #(
    parameter int MDU_MAX   = 64,
    parameter int FLUSH_LAT = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_valid,
    input  logic             ex_reg_w_en,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_mdu,
    input  logic             ex_redirect,
    input  logic             mem_valid,
    input  logic             mem_reg_w_en,
    input  logic [4:0]       mem_rd,
    input  logic             mdu_done,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             hold_ex,
    output logic             bubble_mem,
    output logic             flush_id,
    output logic [1:0]       fwd1,
    output logic [1:0]       fwd2,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MCNT_W = $clog2(MDU_MAX + 1) + 1;

    typedef enum logic [1:0] {RUN, MDU_WAIT, FLUSH} state_t;

    state_t            state_reg, state_next;
    logic [MCNT_W-1:0] mcnt_reg, mcnt_next;
    logic [2:0]        fcnt_reg, fcnt_next;
    logic              timeout_reg, timeout_next;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic [1:0][4:0]   src;
    logic [1:0]        chk;
    logic [1:0]        hit_ex;
    logic [1:0]        hit_mem;
    logic [1:0][1:0]   fwd_sel;
    logic              load_use;
    logic              stall_c, bubble_ex_c, hold_c, flush_c;

    assign src[0] = id_rs;
    assign src[1] = id_rt;
    assign chk[0] = id_valid & id_use_rs;
    assign chk[1] = id_valid & id_use_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign hit_ex[gi]  = chk[gi] & ex_valid & ex_reg_w_en &
                                 (ex_rd == src[gi]) & (src[gi] != 5'd0);
            assign hit_mem[gi] = chk[gi] & mem_valid & mem_reg_w_en &
                                 (mem_rd == src[gi]) & (src[gi] != 5'd0);
            // A load in EX has no result yet, so it cannot forward from EX.
            assign fwd_sel[gi] = (hit_ex[gi] & ~ex_is_load) ? 2'd1 :
                                 hit_mem[gi]                ? 2'd2 : 2'd0;
        end
    endgenerate

    assign load_use = (|hit_ex) & ex_is_load;

    always_comb begin
        state_next   = state_reg;
        mcnt_next    = mcnt_reg;
        fcnt_next    = fcnt_reg;
        timeout_next = timeout_reg;
        stall_c      = 1'b0;
        bubble_ex_c  = 1'b0;
        hold_c       = 1'b0;
        flush_c      = 1'b0;
        case (state_reg)
            RUN: begin
                if (ex_redirect & ex_valid) begin
                    flush_c = 1'b1;
                    if (FLUSH_LAT != 0) begin
                        state_next = FLUSH;
                        fcnt_next  = 3'(FLUSH_LAT);
                    end
                end else if (ex_valid & ex_is_mdu & ~mdu_done) begin
                    stall_c    = 1'b1;
                    hold_c     = 1'b1;
                    state_next = MDU_WAIT;
                    mcnt_next  = MCNT_W'(1);
                end else if (load_use) begin
                    stall_c     = 1'b1;
                    bubble_ex_c = 1'b1;
                end
            end
            MDU_WAIT: begin
                if (mdu_done) begin
                    state_next = RUN;
                    mcnt_next  = '0;
                end else if (mcnt_reg == MCNT_W'(MDU_MAX)) begin
                    // Give up on the unit and release EX as though it had finished.
                    timeout_next = 1'b1;
                    state_next   = RUN;
                    mcnt_next    = '0;
                end else begin
                    stall_c   = 1'b1;
                    hold_c    = 1'b1;
                    mcnt_next = mcnt_reg + MCNT_W'(1);
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (fcnt_reg <= 3'd1) begin
                    state_next = RUN;
                    fcnt_next  = 3'd0;
                end else begin
                    fcnt_next = fcnt_reg - 3'd1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= RUN;
            mcnt_reg      <= '0;
            fcnt_reg      <= '0;
            timeout_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mcnt_reg    <= mcnt_next;
            fcnt_reg    <= fcnt_next;
            timeout_reg <= timeout_next;
            if (stall_c && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_if    = stall_c;
    assign stall_id    = stall_c;
    assign bubble_ex   = bubble_ex_c;
    assign hold_ex     = hold_c;
    assign bubble_mem  = hold_c;
    assign flush_id    = flush_c;
    assign fwd1        = fwd_sel[0];
    assign fwd2        = fwd_sel[1];
    assign mdu_timeout = timeout_reg;
    assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_ysyx_22041071_hazard_ctrl.sv
// Directed bench for the hazard controller: a table of single-cycle forwarding and
// load-use vectors, then hand sequences for MUL/DIV hold, timeout, flush and reset.
module tb_ysyx_22041071_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs, id_use_rt;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        ex_valid, ex_reg_w_en, ex_is_load, ex_is_mdu, ex_redirect;
    logic        mem_valid, mem_reg_w_en, mdu_done;
    logic        stall_if, stall_id, bubble_ex, hold_ex, bubble_mem, flush_id;
    logic [1:0]  fwd1, fwd2;
    logic        mdu_timeout;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22041071_hazard_ctrl #(.MDU_MAX(64), .FLUSH_LAT(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_valid(ex_valid), .ex_reg_w_en(ex_reg_w_en), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_is_mdu(ex_is_mdu), .ex_redirect(ex_redirect),
        .mem_valid(mem_valid), .mem_reg_w_en(mem_reg_w_en), .mem_rd(mem_rd),
        .mdu_done(mdu_done),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .hold_ex(hold_ex), .bubble_mem(bubble_mem), .flush_id(flush_id),
        .fwd1(fwd1), .fwd2(fwd2), .mdu_timeout(mdu_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int idv, rs, rt, urs, urt;
        int exv, exw, exl, exrd;
        int memv, memw, memrd;
        int f1, f2, lu;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_valid = 0; ex_reg_w_en = 0; ex_is_load = 0; ex_rd = 0;
        ex_is_mdu = 0; ex_redirect = 0;
        mem_valid = 0; mem_reg_w_en = 0; mem_rd = 0; mdu_done = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic check_ctrl(input string tag, input int st, input int bex, input int hld,
                              input int fl);
        check({tag, ".stall_if"}, 32'(stall_if), 32'(st));
        check({tag, ".stall_id"}, 32'(stall_id), 32'(st));
        check({tag, ".bubble_ex"}, 32'(bubble_ex), 32'(bex));
        check({tag, ".hold_ex"}, 32'(hold_ex), 32'(hld));
        check({tag, ".bubble_mem"}, 32'(bubble_mem), 32'(hld));
        check({tag, ".flush_id"}, 32'(flush_id), 32'(fl));
    endtask

    initial begin
        int exp_cnt;
        int n;

        //            name           idv rs rt urs urt exv exw exl exrd memv memw memrd f1 f2 lu
        vecs[0]  = '{"ex_fwd_rs",     1, 5, 0, 1, 0,   1, 1, 0, 5,   0, 0, 0,   1, 0, 0};
        vecs[1]  = '{"mem_fwd_rs",    1, 5, 0, 1, 0,   0, 0, 0, 0,   1, 1, 5,   2, 0, 0};
        vecs[2]  = '{"ex_over_mem",   1, 5, 0, 1, 0,   1, 1, 0, 5,   1, 1, 5,   1, 0, 0};
        vecs[3]  = '{"load_use_rt",   1, 1, 7, 1, 1,   1, 1, 1, 7,   0, 0, 0,   0, 0, 1};
        vecs[4]  = '{"mem_fwd_rt",    1, 1, 7, 1, 1,   0, 0, 0, 0,   1, 1, 7,   0, 2, 0};
        vecs[5]  = '{"x0_no_hazard",  1, 0, 0, 1, 1,   1, 1, 1, 0,   1, 1, 0,   0, 0, 0};
        vecs[6]  = '{"rs_unused",     1, 5, 0, 0, 0,   1, 1, 1, 5,   1, 1, 5,   0, 0, 0};
        vecs[7]  = '{"id_invalid",    0, 5, 5, 1, 1,   1, 1, 1, 5,   0, 0, 0,   0, 0, 0};
        vecs[8]  = '{"ex_no_wen",     1, 5, 0, 1, 0,   1, 0, 0, 5,   1, 1, 5,   2, 0, 0};
        vecs[9]  = '{"ex_invalid",    1, 0, 9, 0, 1,   0, 1, 1, 9,   1, 1, 9,   0, 2, 0};
        vecs[10] = '{"lu_rs_mem_rt",  1, 5, 6, 1, 1,   1, 1, 1, 5,   1, 1, 6,   0, 2, 1};

        idle();
        reset = 1'b0;
        #2;
        check("reset.stall_cnt", stall_cnt, 0);
        check("reset.mdu_timeout", 32'(mdu_timeout), 0);
        check_ctrl("reset", 0, 0, 0, 0);
        do_reset();

        exp_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            id_valid = 1'(vecs[i].idv); id_rs = 5'(vecs[i].rs); id_rt = 5'(vecs[i].rt);
            id_use_rs = 1'(vecs[i].urs); id_use_rt = 1'(vecs[i].urt);
            ex_valid = 1'(vecs[i].exv); ex_reg_w_en = 1'(vecs[i].exw);
            ex_is_load = 1'(vecs[i].exl); ex_rd = 5'(vecs[i].exrd);
            mem_valid = 1'(vecs[i].memv); mem_reg_w_en = 1'(vecs[i].memw);
            mem_rd = 5'(vecs[i].memrd);
            @(negedge clk);
            $display("vec %0d %s: fwd1=%0d fwd2=%0d stall_id=%0d bubble_ex=%0d",
                     i, vecs[i].name, fwd1, fwd2, stall_id, bubble_ex);
            check({vecs[i].name, ".fwd1"}, 32'(fwd1), 32'(vecs[i].f1));
            check({vecs[i].name, ".fwd2"}, 32'(fwd2), 32'(vecs[i].f2));
            check_ctrl(vecs[i].name, vecs[i].lu, vecs[i].lu, 0, 0);
            exp_cnt += vecs[i].lu;
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("table.stall_cnt", stall_cnt, 32'(exp_cnt));
        next_cycle();

        // Load-use then forward from MEM on the following cycle.
        do_reset();
        id_valid = 1; id_rs = 1; id_rt = 7; id_use_rt = 1;
        ex_valid = 1; ex_reg_w_en = 1; ex_is_load = 1; ex_rd = 7;
        @(negedge clk);
        $display("seq load_use c0: stall_id=%0d bubble_ex=%0d", stall_id, bubble_ex);
        check_ctrl("lu.c0", 1, 1, 0, 0);
        next_cycle();
        ex_valid = 0; ex_reg_w_en = 0; ex_is_load = 0; ex_rd = 0;
        mem_valid = 1; mem_reg_w_en = 1; mem_rd = 7;
        @(negedge clk);
        $display("seq load_use c1: fwd2=%0d stall_cnt=%0d", fwd2, stall_cnt);
        check("lu.c1.fwd2", 32'(fwd2), 2);
        check_ctrl("lu.c1", 0, 0, 0, 0);
        check("lu.stall_cnt", stall_cnt, 1);

        // DIV with mdu_done five cycles after entering EX.
        do_reset();
        ex_valid = 1; ex_is_mdu = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            $display("seq div c%0d: stall_id=%0d hold_ex=%0d", c, stall_id, hold_ex);
            check_ctrl($sformatf("div.c%0d", c), 1, 0, 1, 0);
            next_cycle();
        end
        mdu_done = 1;
        @(negedge clk);
        $display("seq div c5: stall_id=%0d hold_ex=%0d", stall_id, hold_ex);
        check_ctrl("div.c5", 0, 0, 0, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check_ctrl("div.after", 0, 0, 0, 0);
        check("div.stall_cnt", stall_cnt, 5);
        check("div.mdu_timeout", 32'(mdu_timeout), 0);

        // mdu_done never arrives: forced release after MDU_MAX stall cycles.
        do_reset();
        ex_valid = 1; ex_is_mdu = 1;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!stall_id) break;
            n++;
            next_cycle();
        end
        $display("seq timeout: stall cycles=%0d hold_ex=%0d", n, hold_ex);
        check("to.stall_cycles", 32'(n), 64);
        check("to.release_hold", 32'(hold_ex), 0);
        check("to.before_flag", 32'(mdu_timeout), 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("to.mdu_timeout", 32'(mdu_timeout), 1);
        check("to.stall_cnt", stall_cnt, 64);
        for (int c = 0; c < 3; c++) next_cycle();
        @(negedge clk);
        check("to.sticky", 32'(mdu_timeout), 1);

        // Redirect coincident with load-use and MDU: flush wins for 1 + FLUSH_LAT cycles.
        do_reset();
        id_valid = 1; id_rt = 7; id_use_rt = 1;
        ex_valid = 1; ex_reg_w_en = 1; ex_is_load = 1; ex_rd = 7;
        ex_is_mdu = 1; ex_redirect = 1;
        @(negedge clk);
        $display("seq redirect c0: flush_id=%0d bubble_ex=%0d", flush_id, bubble_ex);
        check_ctrl("rd.c0", 0, 0, 0, 1);
        next_cycle();
        ex_redirect = 0;
        @(negedge clk);
        $display("seq redirect c1: flush_id=%0d stall_id=%0d", flush_id, stall_id);
        check_ctrl("rd.c1", 0, 0, 0, 1);
        next_cycle();
        idle();
        @(negedge clk);
        check_ctrl("rd.c2", 0, 0, 0, 0);
        check("rd.stall_cnt", stall_cnt, 0);

        // Asynchronous reset in the middle of MDU_WAIT.
        do_reset();
        ex_valid = 1; ex_is_mdu = 1;
        for (int c = 0; c < 3; c++) next_cycle();
        @(negedge clk);
        check("rst.pre_hold", 32'(hold_ex), 1);
        #2;
        reset = 1'b0;
        ex_valid = 0;
        #1;
        $display("seq reset_mid: stall_id=%0d hold_ex=%0d stall_cnt=%0d",
                 stall_id, hold_ex, stall_cnt);
        check_ctrl("rst.now", 0, 0, 0, 0);
        check("rst.stall_cnt", stall_cnt, 0);
        next_cycle();
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        check_ctrl("rst.after", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
